// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch stage: FSM state encoding, the NOP
//   instruction loaded into decode on flush/reset, the default reset PC and
//   a small PC increment helper.
//
//   Optional feature macro used by fetch_ctrl: FETCH_PERF_CNT_EN
// -----------------------------------------------------------------------------
package fetch_pkg;

  // REQ     : presenting a request at PC
  // WAIT    : one request outstanding, result goes to IF/ID
  // DISCARD : one request outstanding, result is stale and will be dropped
  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential PC; wraps modulo 2^32 with no alignment check.
  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// -----------------------------------------------------------------------------
// fetch_if_id_reg
//   IF/ID pipeline register: instruction, PC, PC+4 and a valid flag.
//
//   Ports:
//     clk, rst        clock and asynchronous active-high reset
//     load            a fresh instruction is available this cycle
//     flush           kill the current entry (wins over stall and load)
//     stall           decode cannot accept; hold a valid entry
//     instrIn/pcIn/pcPlus4In  data captured on load
//     InstrD/PCD/PCPlus4D/ValidD  register outputs to decode
//
//   On flush only ValidD and InstrD change; PC fields keep their last value.
//   When a valid entry is consumed with nothing new behind it, ValidD drops
//   but the data fields are left untouched.
// -----------------------------------------------------------------------------
module fetch_if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  input  logic [31:0] pcPlus4In,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // A valid entry that decode is refusing must not be overwritten.
  logic holdD;
  assign holdD = stall && ValidD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidD <= 1'b0;
    end else if (flush) begin
      ValidD <= 1'b0;
    end else if (!holdD) begin
      ValidD <= load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
    end else if (flush) begin
      InstrD   <= NOP_INSTR;
    end else if (load && !holdD) begin
      InstrD   <= instrIn;
      PCD      <= pcIn;
      PCPlus4D <= pcPlus4In;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Fetch-stage sequencer against a variable-latency instruction memory with
//   valid/ready request and response channels. Owns the PC, the single
//   outstanding request and the IF/ID register.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     PCSrcE, PCTargetE        redirect from execute (highest priority)
//     StallD                   decode cannot accept; IF/ID holds
//     imem_req_valid/ready/addr   request channel (addr = PC)
//     imem_rsp_valid/ready/data   response channel (memory holds until taken)
//     InstrD, PCD, PCPlus4D, ValidD   IF/ID register outputs
//   Optional (FETCH_PERF_CNT_EN defined):
//     fetch_cnt                IF/ID loads of a real instruction
//     discard_cnt              responses dropped after a redirect
//
//   Configuration macro: FETCH_PERF_CNT_EN
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] discard_cnt
`endif
);

  import fetch_pkg::*;

  fetchState_t state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] reqPc, reqPcNext;
  logic [31:0] reqPcPlus4;
  logic        reqFire, rspFire;
  logic        loadD;
  logic        dropRsp;

  assign reqPcPlus4    = pcPlus4(reqPc);
  assign imem_req_addr = pc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REQ;
      pc    <= RESET_PC;
      reqPc <= RESET_PC;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      reqPc <= reqPcNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake outputs, next state and IF/ID control
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    stateNext      = state;
    pcNext         = pc;
    reqPcNext      = reqPc;
    loadD          = 1'b0;
    dropRsp        = 1'b0;

    // Both channels are quiet while reset is held, even though the state
    // register already sits in REQ.
    if (!rst) begin
      unique case (state)
        REQ:     imem_req_valid = 1'b1;
        // A redirect makes the response stale, so it can be taken even if
        // decode is stalled.
        WAIT:    imem_rsp_ready = PCSrcE || !ValidD || !StallD;
        DISCARD: imem_rsp_ready = 1'b1;
        default: ;
      endcase
    end

    reqFire = imem_req_valid && imem_req_ready;
    rspFire = imem_rsp_valid && imem_rsp_ready;

    unique case (state)
      REQ: begin
        if (reqFire) begin
          reqPcNext = pc;
          // A request accepted in the redirect cycle is already stale.
          stateNext = PCSrcE ? DISCARD : WAIT;
        end
      end
      WAIT: begin
        if (rspFire) begin
          stateNext = REQ;
          if (PCSrcE) begin
            dropRsp = 1'b1;
          end else begin
            loadD  = 1'b1;
            pcNext = reqPcPlus4;
          end
        end else if (PCSrcE) begin
          stateNext = DISCARD;
        end
      end
      DISCARD: begin
        if (rspFire) begin
          dropRsp   = 1'b1;
          stateNext = REQ;
        end
      end
      default: stateNext = REQ;
    endcase

    // Redirect target overrides any sequential PC update.
    if (PCSrcE) begin
      pcNext = PCTargetE;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  fetch_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (loadD),
    .flush     (PCSrcE),
    .stall     (StallD),
    .instrIn   (imem_rsp_data),
    .pcIn      (reqPc),
    .pcPlus4In (reqPcPlus4),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Free-running wrapping event counters: [0] fetches, [1] discards
  // ---------------------------------------------------------------------------
  logic [1:0]  cntInc;
  logic [31:0] cntQ [2];

  assign cntInc = {dropRsp, loadD};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cntQ[gi] <= 32'd0;
        end else if (cntInc[gi]) begin
          cntQ[gi] <= cntQ[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign fetch_cnt   = cntQ[0];
  assign discard_cnt = cntQ[1];
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl. A behavioural memory answers each
//   accepted request after a programmable latency and holds the response
//   until it is taken. Every accepted request that is not killed by a
//   redirect is pushed to a scoreboard; each fresh IF/ID entry pops it.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] discard_cnt;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .StallD         (StallD),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .discard_cnt    (discard_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] expReq;
    logic [31:0] expPc0;
    logic [31:0] expPc4;
    logic [31:0] expPc1;
  } vec_t;

  int          nChecks = 0;
  int          nFails  = 0;
  int          nDecoded = 0;
  exp_t        sbq[$];
  logic [31:0] decodedPc[$];
  logic [31:0] decodedP4[$];
  logic [31:0] reqLog[$];

  bit          memPending = 1'b0;
  int          memCnt = 0;
  logic [31:0] memAddr = 32'd0;
  int          latency = 1;

  bit          lastReqFire, lastRspFire, lastRspReady;
  logic [31:0] heldPc;
  vec_t        vecs[5];
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] discBefore;
`endif

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // One clock cycle. Called just after a rising edge with inputs set.
  task automatic step();
    logic        pcsrc, vBefore, sBefore;
    logic [31:0] reqAddr;
    exp_t        e;
    #1;
    lastReqFire  = imem_req_valid && imem_req_ready;
    lastRspFire  = imem_rsp_valid && imem_rsp_ready;
    lastRspReady = imem_rsp_ready;
    reqAddr      = imem_req_addr;
    pcsrc        = PCSrcE;
    vBefore      = ValidD;
    sBefore      = StallD;
    @(posedge clk);
    #1;
    if (lastRspFire) memPending = 1'b0;
    if (lastReqFire) begin
      memPending = 1'b1;
      memAddr    = reqAddr;
      memCnt     = latency - 1;
      reqLog.push_back(reqAddr);
    end else if (memPending && memCnt > 0) begin
      memCnt--;
    end
    imem_rsp_valid = memPending && (memCnt == 0);
    imem_rsp_data  = memPending ? memData(memAddr) : 32'd0;

    if (ValidD && !(vBefore && sBefore)) begin
      if (sbq.size() == 0) begin
        failNow($sformatf("unexpected_decode pc=0x%08h", PCD));
      end else begin
        e = sbq.pop_front();
        check("dec_pc", PCD, e.addr);
        check("dec_instr", InstrD, e.instr);
        check("dec_pcplus4", PCPlus4D, e.addr + 32'd4);
        $display("decode pc=0x%08h instr=0x%08h pc4=0x%08h", PCD, InstrD, PCPlus4D);
      end
      decodedPc.push_back(PCD);
      decodedP4.push_back(PCPlus4D);
      nDecoded++;
    end
    if (pcsrc) sbq.delete();
    if (lastReqFire && !pcsrc) sbq.push_back('{reqAddr, memData(reqAddr)});
  endtask

  task automatic runUntilDecoded(input int n, input int budget, input string name);
    int k = 0;
    while (decodedPc.size() < n && k < budget) begin
      step();
      k++;
    end
    if (decodedPc.size() < n) failNow({name, "_decode_timeout"});
  endtask

  task automatic runUntilReq(input int n, input int budget, input string name);
    int k = 0;
    while (reqLog.size() < n && k < budget) begin
      step();
      k++;
    end
    if (reqLog.size() < n) failNow({name, "_req_timeout"});
  endtask

  task automatic waitReqFire(input int budget, input string name);
    int k = 0;
    lastReqFire = 1'b0;
    while (!lastReqFire && k < budget) begin
      step();
      k++;
    end
    if (!lastReqFire) failNow({name, "_reqfire_timeout"});
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'h0000_2000, 3, 32'h0000_2000, 32'h0000_2000, 32'h0000_2004, 32'h0000_2004};
    vecs[3] = '{32'h7FFF_FFF8, 2, 32'h7FFF_FFF8, 32'h7FFF_FFF8, 32'h7FFF_FFFC, 32'h7FFF_FFFC};
    vecs[4] = '{32'h0000_0040, 4, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 32'h0000_0044};

    rst = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'd0; StallD = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_rsp_ready", imem_rsp_ready, 0);
    check("rst_validd", ValidD, 0);
    check("rst_instrd", InstrD, NOP);
    check("rst_pcd", PCD, 0);
    check("rst_pcplus4d", PCPlus4D, 0);
    rst = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, RESET_PC);

    // Sequential fetch, 1-cycle memory
    latency = 1;
    runUntilDecoded(3, 30, "seq");
    runUntilReq(4, 30, "seq");
    check("seq_req0", reqLog[0], 32'h0);
    check("seq_req1", reqLog[1], 32'h4);
    check("seq_req2", reqLog[2], 32'h8);
    check("seq_req3", reqLog[3], 32'hC);
    check("seq_dec0", decodedPc[0], 32'h0);
    check("seq_dec1", decodedPc[1], 32'h4);
    check("seq_dec2", decodedPc[2], 32'h8);

    // Decode stall for 3 cycles on a valid entry
    runUntilDecoded(decodedPc.size() + 1, 10, "stall_pre");
    heldPc = PCD;
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_validd", ValidD, 1);
      check("stall_pcd", PCD, heldPc);
      check("stall_rsp_ready", lastRspReady, 0);
    end
    check("stall_rsp_pending", imem_rsp_valid, 1);
    StallD = 1'b0;
    step();
    check("unstall_rsp_fire", lastRspFire, 1);
    check("unstall_validd", ValidD, 1);
    check("unstall_pcd", PCD, heldPc + 32'd4);

    // Redirect in WAIT, response 3 cycles later
    latency = 3;
    waitReqFire(10, "redir_wait");
`ifdef FETCH_PERF_CNT_EN
    discBefore = discard_cnt;
`endif
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
    reqLog.delete(); decodedPc.delete(); decodedP4.delete();
    step();
    PCSrcE = 1'b0;
    check("redir_validd", ValidD, 0);
    check("redir_instrd", InstrD, NOP);
    check("redir_addr", imem_req_addr, 32'h100);
    runUntilReq(1, 20, "redir");
    check("redir_first_req", reqLog[0], 32'h100);
`ifdef FETCH_PERF_CNT_EN
    check("redir_discard_cnt", discard_cnt, discBefore + 32'd1);
`endif
    runUntilDecoded(1, 20, "redir");
    check("redir_dec0", decodedPc[0], 32'h100);

    // Redirect in the same WAIT cycle the response arrives
    latency = 2;
    waitReqFire(10, "same");
    step();
    check("same_rsp_pending", imem_rsp_valid, 1);
`ifdef FETCH_PERF_CNT_EN
    discBefore = discard_cnt;
`endif
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
    decodedPc.delete(); decodedP4.delete();
    step();
    PCSrcE = 1'b0;
    check("same_rsp_fire", lastRspFire, 1);
    check("same_req_valid", imem_req_valid, 1);
    check("same_req_addr", imem_req_addr, 32'h300);
    check("same_validd", ValidD, 0);
`ifdef FETCH_PERF_CNT_EN
    check("same_discard_cnt", discard_cnt, discBefore + 32'd1);
`endif
    runUntilDecoded(1, 20, "same");
    check("same_dec0", decodedPc[0], 32'h300);

    // Asynchronous reset in WAIT while decode holds a stalled valid entry
    latency = 3;
    runUntilDecoded(decodedPc.size() + 1, 20, "rstmid_pre");
    StallD = 1'b1;
    step();
    check("rstmid_pre_validd", ValidD, 1);
    rst = 1'b1; StallD = 1'b0;
    memPending = 1'b0; imem_rsp_valid = 1'b0; sbq.delete();
    #1;
    check("rstmid_validd", ValidD, 0);
    check("rstmid_req_valid", imem_req_valid, 0);
    check("rstmid_rsp_ready", imem_rsp_ready, 0);
    check("rstmid_pc", imem_req_addr, RESET_PC);
    check("rstmid_instrd", InstrD, NOP);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rstrel_req_valid", imem_req_valid, 1);
    check("rstrel_req_addr", imem_req_addr, RESET_PC);
    nDecoded = 0;
    decodedPc.delete(); decodedP4.delete();
    runUntilDecoded(1, 20, "rstrel");
    check("rstrel_dec0", decodedPc[0], RESET_PC);

    // Table of redirect targets and latencies, including PC wrap
    for (int v = 0; v < 5; v++) begin
      latency = vecs[v].lat;
      PCSrcE = 1'b1; PCTargetE = vecs[v].target;
      decodedPc.delete(); decodedP4.delete();
      step();
      PCSrcE = 1'b0;
      check($sformatf("vec%0d_addr", v), imem_req_addr, vecs[v].expReq);
      check($sformatf("vec%0d_validd", v), ValidD, 0);
      runUntilDecoded(2, 40, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_pc0", v), decodedPc[0], vecs[v].expPc0);
      check($sformatf("vec%0d_pc4", v), decodedP4[0], vecs[v].expPc4);
      check($sformatf("vec%0d_pc1", v), decodedPc[1], vecs[v].expPc1);
    end

    // Randomised stalls, back-pressure, latencies and redirects
    for (int i = 0; i < 200; i++) begin
      latency        = int'($urandom_range(1, 3));
      StallD         = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      PCSrcE         = ($urandom_range(0, 15) == 0);
      PCTargetE      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step();
    end

    // Drain: everything still expected must arrive
    PCSrcE = 1'b0; StallD = 1'b0; imem_req_ready = 1'b0;
    repeat (12) step();
    check("drain_sb_empty", sbq.size(), 0);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt_total", fetch_cnt, nDecoded);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch stage against a variable-latency instruction memory using request/response valid-ready handshakes.
- Owns the PC register, the single outstanding request, and the IF/ID pipeline register (instruction, PC, PC+4, valid).
- Applies execute-stage redirects, discards stale responses, and honours decode stalls.
- Sits between the execute-stage branch resolution (PCSrcE/PCTargetE) and the decode stage.

Parameters:
- RESET_PC, 32'h00000000, PC fetched first after reset.
- NOP_INSTR, 32'h00000013, value loaded into InstrD on flush/reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCSrcE  in  1  redirect request from execute.
- PCTargetE  in  32  redirect target.
- StallD  in  1  decode cannot accept; IF/ID must hold.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  request address (= PC).
- imem_rsp_valid  in  1  response valid; memory holds it until accepted.
- imem_rsp_ready  out  1  controller accepts response.
- imem_rsp_data  in  32  fetched instruction.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: PC=RESET_PC, state=REQ, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. While rst is high, imem_req_valid=0 and imem_rsp_ready=0.
- Outstanding requests: at most one; the memory must not return responses out of order.
- States:
  - REQ: imem_req_valid=1, imem_req_addr=PC. Handshake (valid&ready): latch req_pc=PC, go WAIT. Latency from reset release to first request is 0 cycles (REQ is entered directly).
  - WAIT: imem_rsp_ready=(!ValidD | !StallD). On rsp handshake: IF/ID <= {rsp_data, req_pc, req_pc+4}, ValidD<=1, PC<=req_pc+4, go REQ. Best case is back-to-back fetch every 2 cycles with a 1-cycle memory.
  - DISCARD: imem_rsp_ready=1. On rsp_valid, drop the data and go REQ.
- Redirect (PCSrcE=1), any state, priority over everything else:
  - PC<=PCTargetE.
  - IF/ID flushed: ValidD<=0, InstrD<=NOP_INSTR. Flush beats StallD.
  - REQ without ready: stay in REQ. The address changes to the target next cycle; the memory samples the address only on handshake.
  - REQ with ready on the same cycle: the request is accepted; go DISCARD.
  - WAIT with no rsp_valid: go DISCARD.
  - WAIT with rsp_valid on the same cycle: accept and drop the response; go REQ.
  - DISCARD: stay DISCARD unless rsp_valid, then go REQ.
- IF/ID update rules:
  - StallD & ValidD & no flush: hold all IF/ID outputs.
  - ValidD & !StallD & no new load: ValidD<=0; data fields hold.
- Arithmetic: PC+4 is 32-bit modulo 2^32; 32'hFFFFFFFC+4 = 0. There is no alignment check.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetch_cnt [31:0] (IF/ID loads with ValidD<=1) and discard_cnt [31:0] (responses dropped).
  - Both counters wrap, reset to 0, and are free-running.
- Undefined: no counters, no ports; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: state enum {REQ, WAIT, DISCARD}, NOP_INSTR constant, default RESET_PC.
- Sub-module fetch_if_id_reg: IF/ID register with load/stall/flush/valid and async reset; instantiated once.

Test Plan:
- Reset release, 1-cycle memory, StallD=0 -> requests at PC 0,4,8,12; ValidD pulses with PCD 0,4,8; PCPlus4D=PCD+4.
- StallD=1 for 3 cycles with ValidD=1 -> IF/ID holds; imem_rsp_ready=0; next response stays pending; accepted the cycle after StallD falls.
- PCSrcE=1 with PCTargetE=0x100 while in WAIT (response 3 cycles later) -> ValidD=0, InstrD=0x13; stale response dropped, discard_cnt=1 (macro on); next request addr 0x100.
- PCSrcE and imem_rsp_valid in the same WAIT cycle -> response dropped; next cycle REQ with addr=target.
- rst asserted mid-WAIT -> immediate ValidD=0, PC=RESET_PC, req_valid=0; after release first request addr=RESET_PC.
- PC=0xFFFFFFFC fetch -> PCPlus4D=0, next request addr 0x00000000.
